prog_load_dump_ctrl: RTL

Parametrised, synthesizable program-load / run / result-dump controller for the pipelined CPU. It replaces hierarchical instruction-memory pokes and data-memory peeks with handshaked ports:
- streams a program into instruction memory while holding the core in reset;
- releases the core for a programmable cycle budget;
- re-holds the core and streams a window of data memory out.
It sits beside pipelined_datapath and drives its reset, imem write port and dmem read port.

---
 rtl/prog_load_dump_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/prog_load_dump_ctrl.sv
// prog_load_dump_ctrl
//   Program-load / run / result-dump sequencer for the pipelined CPU.
//   A start request streams a program into instruction memory with the core
//   held in reset, releases the core for a captured cycle budget, then re-holds
//   it and streams DUMP_WORDS words of data memory out, starting at address 0.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start, run_cycles begin a sequence (IDLE/DONE only), budget captured then
//   load_*            program beat stream in (valid/ready)
//   imem_*            instruction memory write port
//   cpu_hold          active-high reset to the core
//   dmem_*            data memory read port (read data one cycle after dmem_re)
//   dump_*            dump beat stream out (valid/ready)
//   busy, done        sequence status; done is sticky until the next start
//   load_ovf          sticky: program longer than IMEM_DEPTH, cleared on start
//   dbg_state         current FSM state
//
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high. The producer holds valid and its payload stable until that edge, and
// valid never depends on ready; ready may be high before valid without effect.

module prog_load_dump_ctrl #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int IMEM_AW    = 6,
  parameter int DMEM_AW    = 8,
  parameter int DUMP_WORDS = 10,
  parameter int CYC_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CYC_W-1:0]   run_cycles,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               load_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               cpu_hold,
  output logic               dmem_re,
  output logic [DMEM_AW-1:0] dmem_addr,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [DMEM_AW-1:0] dump_addr,
  output logic [DATA_W-1:0]  dump_data,
  output logic               dump_last,
  output logic               busy,
  output logic               done,
  output logic               load_ovf,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RUN      = 3'd2,
    S_DUMP_RD  = 3'd3,
    S_DUMP_OUT = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  localparam logic [IMEM_AW-1:0] WIDX_MAX  = IMEM_AW'(IMEM_DEPTH - 1);
  localparam logic [DMEM_AW-1:0] RIDX_LAST = DMEM_AW'(DUMP_WORDS - 1);

  state_e             state_q, state_d;
  logic [CYC_W-1:0]   run_cnt_q, run_cnt_d;
  logic [IMEM_AW-1:0] widx_q, widx_d;
  logic [DMEM_AW-1:0] ridx_q, ridx_d;
  logic [DMEM_AW-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0]  dump_data_q, dump_data_d;
  logic               dump_last_q, dump_last_d;
  logic               first_q, first_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               done_q, done_d;
  logic               load_ovf_q, load_ovf_d;
  logic               load_xfer;

  assign load_xfer = (state_q == S_LOAD) && load_valid;

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    widx_d      = widx_q;
    ridx_d      = ridx_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    dump_last_d = dump_last_q;
    first_d     = 1'b0;
    done_d      = done_q;
    load_ovf_d  = load_ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          run_cnt_d  = run_cycles;
          widx_d     = '0;
          ridx_d     = '0;
          done_d     = 1'b0;
          load_ovf_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_xfer) begin
          if (load_last) begin
            state_d = S_RUN;
          end else if (widx_q == WIDX_MAX) begin
            // Memory full without a last beat: stop accepting, flag it, run anyway.
            state_d    = S_RUN;
            load_ovf_d = 1'b1;
          end else begin
            widx_d = widx_q + IMEM_AW'(1);
          end
        end
      end
      S_RUN: begin
        if (run_cnt_q == '0) begin
          state_d = S_DUMP_RD;
        end else begin
          run_cnt_d = run_cnt_q - CYC_W'(1);
        end
      end
      S_DUMP_RD: begin
        state_d     = S_DUMP_OUT;
        dump_addr_d = ridx_q;
        dump_last_d = (ridx_q == RIDX_LAST);
        first_d     = 1'b1;
      end
      S_DUMP_OUT: begin
        // Read data is only guaranteed in the first DUMP_OUT cycle; keep a copy
        // so the beat stays stable however long the sink stalls.
        if (first_q) begin
          dump_data_d = dmem_rdata;
        end
        if (dump_ready) begin
          if (dump_last_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DUMP_RD;
            ridx_d  = ridx_q + DMEM_AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The core runs only while the counter still has budget left, so a zero
    // budget spends its single RUN cycle with the core still held.
    cpu_hold_d = !((state_d == S_RUN) && (run_cnt_d != '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      run_cnt_q   <= '0;
      widx_q      <= '0;
      ridx_q      <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
      dump_last_q <= 1'b0;
      first_q     <= 1'b0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      load_ovf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      widx_q      <= widx_d;
      ridx_q      <= ridx_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
      dump_last_q <= dump_last_d;
      first_q     <= first_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      load_ovf_q  <= load_ovf_d;
    end
  end

  assign load_ready = (state_q == S_LOAD);
  assign imem_we    = load_xfer;
  assign imem_addr  = load_xfer ? widx_q : '0;
  assign imem_wdata = load_xfer ? load_data : '0;
  assign cpu_hold   = cpu_hold_q;
  assign dmem_re    = (state_q == S_DUMP_RD);
  assign dmem_addr  = dmem_re ? ridx_q : '0;
  assign dump_valid = (state_q == S_DUMP_OUT);
  assign dump_addr  = dump_valid ? dump_addr_q : '0;
  assign dump_data  = !dump_valid ? '0 : (first_q ? dmem_rdata : dump_data_q);
  assign dump_last  = dump_valid && dump_last_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = done_q;
  assign load_ovf   = load_ovf_q;
  assign dbg_state  = state_q;

endmodule
